// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared types, defaults and sizing helper for the shift frame controller
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } shift_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_GAP   = 1;

    // Bits needed to count 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_frame_controller_core.sv
// rtl/shift_frame_controller_core.sv - shift_reg_core: WIDTH-bit left-shift register with load and clear
module shift_reg_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/shift_frame_controller.sv
// rtl/shift_frame_controller.sv - MSB-first frame serializer sequencer; optional parity via SHIFT_FRAME_PARITY_EN
module shift_frame_controller #(
    parameter int WIDTH = shift_ctrl_pkg::DEFAULT_WIDTH,
    parameter int GAP   = shift_ctrl_pkg::DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);
    import shift_ctrl_pkg::*;

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : GAP - 1);
    // With no gap the frame returns straight to IDLE.
    localparam shift_state_t POST_FRAME = (GAP == 0) ? IDLE : shift_ctrl_pkg::GAP;

    shift_state_t  state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap_cnt;
    logic          load;
    logic          shift_en;
`ifdef SHIFT_FRAME_PARITY_EN
    logic          par;
`endif

    assign load     = (state == IDLE) && tx_valid;
    assign shift_en = (state == SHIFT);

    shift_reg_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d        (tx_data),
        .q        (q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        cnt   <= '0;
                        state <= SHIFT;
`ifdef SHIFT_FRAME_PARITY_EN
                        par   <= ^tx_data;
`endif
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef SHIFT_FRAME_PARITY_EN
                        state   <= PARITY;
`else
                        state   <= POST_FRAME;
                        done    <= 1'b1;
                        gap_cnt <= '0;
`endif
                    end
                end
                PARITY: begin
`ifdef SHIFT_FRAME_PARITY_EN
                    state   <= POST_FRAME;
                    done    <= 1'b1;
                    gap_cnt <= '0;
`else
                    state   <= IDLE;
`endif
                end
                shift_ctrl_pkg::GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign ser_en   = (state == SHIFT) || (state == PARITY);

    always_comb begin
        ser_out = 1'b0;
        if (state == SHIFT) begin
            ser_out = q[WIDTH-1];
        end
`ifdef SHIFT_FRAME_PARITY_EN
        else if (state == PARITY) begin
            ser_out = par;
        end
`endif
    end

endmodule

// File: tb/tb_shift_frame_controller.sv
// tb/tb_shift_frame_controller.sv - self-checking bench for shift_frame_controller across three configurations
module tb_shift_frame_controller;

`ifdef SHIFT_FRAME_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid [3];
    logic [31:0] tx_data  [3];
    logic        rdy [3];
    logic        sout[3];
    logic        sen [3];
    logic        bsy [3];
    logic        dn  [3];
    logic [3:0]  q0, q1;
    logic [7:0]  q2;
    logic [31:0] qv [3];
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    assign qv[0] = {28'd0, q0};
    assign qv[1] = {28'd0, q1};
    assign qv[2] = {24'd0, q2};

    shift_frame_controller #(.WIDTH(4), .GAP(1)) u0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[0]), .tx_data(tx_data[0][3:0]),
        .tx_ready(rdy[0]), .ser_out(sout[0]), .ser_en(sen[0]), .busy(bsy[0]), .done(dn[0]), .q(q0)
    );
    shift_frame_controller #(.WIDTH(4), .GAP(0)) u1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[1]), .tx_data(tx_data[1][3:0]),
        .tx_ready(rdy[1]), .ser_out(sout[1]), .ser_en(sen[1]), .busy(bsy[1]), .done(dn[1]), .q(q1)
    );
    shift_frame_controller #(.WIDTH(8), .GAP(3)) u2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid[2]), .tx_data(tx_data[2][7:0]),
        .tx_ready(rdy[2]), .ser_out(sout[2]), .ser_en(sen[2]), .busy(bsy[2]), .done(dn[2]), .q(q2)
    );

    function automatic int wid(input int i);
        return (i == 2) ? 8 : 4;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk($sformatf("%s u%0d q", tag, i), qv[i], 32'd0);
        chk($sformatf("%s u%0d ser_en", tag, i), {31'd0, sen[i]}, 32'd0);
        chk($sformatf("%s u%0d busy", tag, i), {31'd0, bsy[i]}, 32'd0);
        chk($sformatf("%s u%0d done", tag, i), {31'd0, dn[i]}, 32'd0);
    endtask

    // Expected per-cycle behaviour derived from the frame timeline:
    // cycle c after acceptance carries bit c-1 (MSB first), then parity,
    // then the gap, then one IDLE cycle; done marks the first post-frame cycle.
    task automatic frame(input int i, input logic [31:0] word_in, input logic [31:0] junk);
        int          w, g, f;
        logic [31:0] mask, word, e_q;
        logic        e_en, e_out, e_busy, e_rdy, e_done;
        w    = wid(i);
        g    = gap_of(i);
        f    = w + P;
        mask = (32'd1 << w) - 32'd1;
        word = word_in & mask;
        chk($sformatf("u%0d pre ready", i), {31'd0, rdy[i]}, 32'd1);
        chk($sformatf("u%0d pre busy", i), {31'd0, bsy[i]}, 32'd0);
        tx_valid[i] = 1'b1;
        tx_data[i]  = word;
        for (int c = 1; c <= f + g + 1; c++) begin
            @(negedge clk);
            tx_valid[i] = 1'b1;
            tx_data[i]  = junk;
            e_q = 32'd0; e_en = 1'b0; e_out = 1'b0; e_busy = 1'b1; e_rdy = 1'b0; e_done = 1'b0;
            if (c <= w) begin
                e_en  = 1'b1;
                e_out = word[w-c];
                e_q   = (word << (c - 1)) & mask;
            end else if (c <= f) begin
                e_en  = 1'b1;
                e_out = ^word;
            end else if (c <= f + g) begin
                e_done = (c == f + 1);
            end else begin
                e_busy = 1'b0;
                e_rdy  = 1'b1;
                e_done = (g == 0);
            end
            chk($sformatf("u%0d w=%0h c%0d q", i, word, c), qv[i], e_q);
            chk($sformatf("u%0d w=%0h c%0d ser_en", i, word, c), {31'd0, sen[i]}, {31'd0, e_en});
            chk($sformatf("u%0d w=%0h c%0d ser_out", i, word, c), {31'd0, sout[i]}, {31'd0, e_out});
            chk($sformatf("u%0d w=%0h c%0d busy", i, word, c), {31'd0, bsy[i]}, {31'd0, e_busy});
            chk($sformatf("u%0d w=%0h c%0d ready", i, word, c), {31'd0, rdy[i]}, {31'd0, e_rdy});
            chk($sformatf("u%0d w=%0h c%0d done", i, word, c), {31'd0, dn[i]}, {31'd0, e_done});
        end
        tx_valid[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("reset u%0d ready", i), {31'd0, rdy[i]}, 32'd1);

        // Reset in the middle of a frame aborts it without a done pulse.
        tx_valid[0] = 1'b1;
        tx_data[0]  = 32'hD;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        chk("midreset ser_en", {31'd0, sen[0]}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_idle(0, "midreset");
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_idle(0, "postreset");
            chk("postreset ready", {31'd0, rdy[0]}, 32'd1);
        end

        frame(0, 32'hD, 32'h6);
        frame(0, 32'h6, $urandom);
        frame(0, 32'h9, $urandom);
        for (int n = 0; n < 6; n++) frame(0, $urandom, $urandom);

        frame(1, 32'h8, 32'h0);
        frame(1, 32'h1, 32'h0);
        for (int n = 0; n < 6; n++) frame(1, $urandom, $urandom);

        frame(2, 32'hA5, $urandom);
        for (int n = 0; n < 5; n++) frame(2, $urandom, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_frame_controller.md
# shift_frame_controller

Sequencer for a left-shift serializer datapath. Accepts a parallel word through a valid/ready handshake, loads it into an embedded left-shift register, and sequences WIDTH shift cycles to emit the word MSB-first on a serial output with a frame-enable strobe. An optional parity bit can follow the word. A programmable inter-frame gap then runs before the next word is accepted. It sits between a word-oriented producer and a serial link or shift-based peripheral.

## Interface
- WIDTH, 4: data word width in bits; legal values are 2..32.
- GAP, 1: number of idle cycles after each frame before tx_ready reasserts; 0 is legal.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (sampled on the rising edge of clk).
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  WIDTH  word to serialize.
- tx_ready  output  1  controller can accept a word this cycle.
- ser_out  output  1  serial data bit, MSB first.
- ser_en  output  1  high on every cycle that carries a valid serial bit.
- busy  output  1  high from the cycle after acceptance until the gap ends.
- done  output  1  one-cycle pulse marking frame completion.
- q  output  WIDTH  current shift-register contents, for observation and debug.

## Operation
- States: IDLE, SHIFT, PARITY (only when parity is compiled in), GAP.
- IDLE
  - tx_ready=1, busy=0.
  - A transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
  - On transfer: q←tx_data, bit counter←0, state→SHIFT.
  - With parity compiled in, the parity register←^tx_data on the same edge.
- SHIFT
  - ser_en=1 and ser_out=q[WIDTH-1].
  - Each edge: q←{q[WIDTH-2:0],1'b0} (zero fill), counter increments.
  - When counter==WIDTH-1 at an edge, the next state is PARITY if parity is compiled in, otherwise GAP, or IDLE when GAP==0.
- PARITY
  - One cycle: ser_en=1, ser_out=parity register, q holds.
  - Next state is GAP, or IDLE when GAP==0.
- GAP
  - ser_en=0 and ser_out=0 for exactly GAP cycles; gap counter counts from 0.
  - Next state is IDLE.
- done
  - Registered; high for exactly one cycle.
  - It is the first cycle after the last serial bit (the first GAP cycle, or the IDLE cycle when GAP==0).
- tx_valid outside IDLE is ignored. tx_ready=0 there, and tx_data is not sampled.
- Counter width is $clog2(WIDTH+1); GAP counter width is $clog2(GAP+1), minimum 1 bit.
- Reset with rst=0 at an edge:
  - state=IDLE, q=0, all counters=0, parity register=0.
  - ser_out=0, ser_en=0, busy=0, done=0; tx_ready=1 once rst deasserts.
  - Reset mid-frame aborts the frame with no done pulse.

## Timing
- Acceptance at edge k. Bit i of the word (i=0 is the MSB) is on ser_out during cycle k+1+i.
- Frame occupies WIDTH cycles of ser_en, or WIDTH+1 with parity compiled in.
- done is high in cycle k+1+WIDTH, or k+2+WIDTH with parity.
- The next acceptance is possible at the edge ending cycle k+1+WIDTH+GAP (+1 with parity).
  - With GAP=0 frames run back-to-back, separated by one IDLE cycle.
- ser_out, ser_en and tx_ready are decoded from registered state and q. There are no combinational paths from tx_valid or tx_data to any output.

## Configuration
- Macro: SHIFT_FRAME_PARITY_EN.
- Defined:
  - PARITY state and parity register are present.
  - The even-parity bit (XOR of the loaded word) is appended as an extra ser_en cycle.
- Undefined:
  - No PARITY state and no parity register.
  - The frame is exactly WIDTH bits; all other behaviour is identical.

## Structure
- Package shift_ctrl_pkg holds:
  - typedef enum logic [1:0] shift_state_t (IDLE, SHIFT, PARITY, GAP);
  - localparam for the default WIDTH and GAP;
  - a function computing counter width.
- Sub-module shift_reg_core is the WIDTH-bit register with synchronous active-low clear, parallel load, and left shift with zero fill.
  - Controls: load, shift_en, d, q.
  - The controller drives it; its q feeds the q port and the ser_out decode.

## Test plan
- Reset: assert rst=0 for 2 cycles during a frame. Required: q=0000, ser_en=0, busy=0, done=0, tx_ready=1 after release, and no done pulse.
- Basic frame (WIDTH=4, GAP=1, parity off): accept 4'b1101.
  - q=1101,1010,0100,1000 over cycles 1–4 and ser_out=1,1,0,1 with ser_en=1.
  - done=1 in cycle 5; tx_ready=1 in cycle 6.
- Parity on: accept 4'b1101. Required: ser_out=1,1,0,1,1 across 5 ser_en cycles and done in cycle 6. Repeat with 4'b1001: the fifth bit must be 0.
- Busy ignore: change tx_valid=1 and tx_data=4'b0110 during SHIFT. Required: tx_ready=0, the serialized word is unchanged, and 0110 is accepted only in the next IDLE.
- Back-to-back (GAP=0): hold tx_valid=1 with words 4'b1000 then 4'b0001.
  - Required serial stream: 1,0,0,0, one idle cycle, then 0,0,0,1.
  - Each word produces one done pulse.
- Wide word (WIDTH=8, GAP=3): accept 8'hA5. Required: ser_out=1,0,1,0,0,1,0,1, then 3 gap cycles with ser_en=0, busy=1 throughout the frame and gap.
